// File: rtl/axi4_burst_master.sv
// axi4_burst_master: command-driven AXI4 burst master.
// Takes one read or write burst command at a time, checks its legality,
// sequences AW/W/B or AR/R, streams data through the local ports and
// reports completion with a one-cycle done pulse and accumulated response.
// Optional feature macro: AXI_MASTER_TIMEOUT_EN adds a per-channel watchdog
// that aborts a stalled burst after TIMEOUT_CYCLES cycles with response 2'b11.
module axi4_burst_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    // local write stream
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    // local read stream
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    // completion
    output logic                  done,
    output logic [1:0]            done_resp,
    // AXI write address channel
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [1:0]            AWBURST,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // AXI write data channel
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    // AXI write response channel
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // AXI read address channel
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [1:0]            ARBURST,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // AXI read data channel
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RLAST,
    input  logic                  RVALID,
    input  logic [1:0]            RRESP,
    output logic                  RREADY
);

    localparam int MAX_SIZE_INT = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0] MAX_SIZE = 3'(MAX_SIZE_INT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHK,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R
    } state_t;

    state_t                state_reg, state_next;
    logic                  write_reg, write_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]            len_reg, len_next;
    logic [2:0]            size_reg, size_next;
    logic [1:0]            burst_reg, burst_next;
    logic [7:0]            cnt_reg, cnt_next;
    logic [1:0]            acc_reg, acc_next;
    logic                  len_err_reg, len_err_next;
    logic                  awvalid_reg, awvalid_next;
    logic                  arvalid_reg, arvalid_next;
    logic                  done_reg, done_next;
    logic [1:0]            done_resp_reg, done_resp_next;

    logic size_bad, wrap_bad, cmd_illegal;

    // Legality of the latched command, evaluated during CHK
    assign size_bad    = (size_reg > MAX_SIZE);
    assign wrap_bad    = (burst_reg == 2'b10) &&
                         !((len_reg == 8'd1) || (len_reg == 8'd3) ||
                           (len_reg == 8'd7) || (len_reg == 8'd15));
    assign cmd_illegal = (burst_reg == 2'b11) || size_bad || wrap_bad;

    // Address channels are driven straight from the latched command
    assign AWADDR    = addr_reg;
    assign AWBURST   = burst_reg;
    assign AWLEN     = len_reg;
    assign AWSIZE    = size_reg;
    assign AWVALID   = awvalid_reg;
    assign ARADDR    = addr_reg;
    assign ARBURST   = burst_reg;
    assign ARLEN     = len_reg;
    assign ARSIZE    = size_reg;
    assign ARVALID   = arvalid_reg;
    assign WDATA     = wr_data;
    assign rd_data   = RDATA;
    assign done      = done_reg;
    assign done_resp = done_resp_reg;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_reg, wd_next;
    logic            chan_busy;
    logic            chan_hs;

    // Which channel the current state waits on, and whether it handshakes now
    always_comb begin
        chan_busy = 1'b1;
        chan_hs   = 1'b0;
        case (state_reg)
            ST_AW:   chan_hs = awvalid_reg & AWREADY;
            ST_W:    chan_hs = wr_valid & WREADY;
            ST_B:    chan_hs = BVALID;
            ST_AR:   chan_hs = arvalid_reg & ARREADY;
            ST_R:    chan_hs = RVALID & rd_ready;
            default: chan_busy = 1'b0;
        endcase
    end

    // Watchdog counter register
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`endif

    // State register
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latched command, beat counter, response tracking and channel valids
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            len_reg       <= '0;
            size_reg      <= '0;
            burst_reg     <= '0;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            len_err_reg   <= 1'b0;
            awvalid_reg   <= 1'b0;
            arvalid_reg   <= 1'b0;
            done_reg      <= 1'b0;
            done_resp_reg <= '0;
        end else begin
            write_reg     <= write_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
            size_reg      <= size_next;
            burst_reg     <= burst_next;
            cnt_reg       <= cnt_next;
            acc_reg       <= acc_next;
            len_err_reg   <= len_err_next;
            awvalid_reg   <= awvalid_next;
            arvalid_reg   <= arvalid_next;
            done_reg      <= done_next;
            done_resp_reg <= done_resp_next;
        end
    end

    // Next-state logic and channel pass-through outputs
    always_comb begin
        state_next     = state_reg;
        write_next     = write_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;
        size_next      = size_reg;
        burst_next     = burst_reg;
        cnt_next       = cnt_reg;
        acc_next       = acc_reg;
        len_err_next   = len_err_reg;
        awvalid_next   = awvalid_reg;
        arvalid_next   = arvalid_reg;
        done_next      = 1'b0;
        done_resp_next = done_resp_reg;
        cmd_ready      = 1'b0;
        wr_ready       = 1'b0;
        WVALID         = 1'b0;
        WLAST          = 1'b0;
        BREADY         = 1'b0;
        RREADY         = 1'b0;
        rd_valid       = 1'b0;
        rd_last        = 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
        wd_next        = '0;
`endif

        case (state_reg)
            ST_IDLE: begin
                // Held off while done is pulsing so the two never overlap
                cmd_ready = ARESET & ~done_reg;
                if (cmd_valid && cmd_ready) begin
                    write_next = cmd_write;
                    addr_next  = cmd_addr;
                    len_next   = cmd_len;
                    size_next  = cmd_size;
                    burst_next = cmd_burst;
                    state_next = ST_CHK;
                end
            end
            ST_CHK: begin
                if (cmd_illegal) begin
                    done_next      = 1'b1;
                    done_resp_next = 2'b10;
                    state_next     = ST_IDLE;
                end else begin
                    cnt_next     = len_reg;
                    acc_next     = 2'b00;
                    len_err_next = 1'b0;
                    if (write_reg) begin
                        awvalid_next = 1'b1;
                        state_next   = ST_AW;
                    end else begin
                        arvalid_next = 1'b1;
                        state_next   = ST_AR;
                    end
                end
            end
            ST_AW: begin
                if (awvalid_reg && AWREADY) begin
                    awvalid_next = 1'b0;
                    state_next   = ST_W;
                end
            end
            ST_W: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                WLAST    = (cnt_reg == 8'd0);
                if (wr_valid && WREADY) begin
                    if (cnt_reg == 8'd0) begin
                        state_next = ST_B;
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
            end
            ST_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    done_next      = 1'b1;
                    done_resp_next = BRESP;
                    state_next     = ST_IDLE;
                end
            end
            ST_AR: begin
                if (arvalid_reg && ARREADY) begin
                    arvalid_next = 1'b0;
                    state_next   = ST_R;
                end
            end
            ST_R: begin
                RREADY   = rd_ready;
                rd_valid = RVALID;
                rd_last  = RLAST;
                if (RVALID && rd_ready) begin
                    acc_next = acc_reg | RRESP;
                    if (cnt_reg != 8'd0) begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                    if (RLAST) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                        // Early or late RLAST is a length mismatch
                        if ((cnt_reg != 8'd0) || len_err_reg) begin
                            done_resp_next = 2'b10;
                        end else begin
                            done_resp_next = acc_reg | RRESP;
                        end
                    end else if (cnt_reg == 8'd0) begin
                        len_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        // Watchdog overrides the state's own decision once it expires
        if (chan_busy) begin
            if (chan_hs) begin
                wd_next = '0;
            end else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                wd_next        = '0;
                awvalid_next   = 1'b0;
                arvalid_next   = 1'b0;
                done_next      = 1'b1;
                done_resp_next = 2'b11;
                state_next     = ST_IDLE;
            end else begin
                wd_next = wd_reg + WD_W'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Testbench for axi4_burst_master: behavioural AXI slave plus scoreboard.
// Expected AW/AR fields, W beats, read beats and done responses are queued
// when stimulus is issued and popped when the DUT produces them.
module tb_axi4_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [1:0]  AWBURST, ARBURST;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, ARVALID, ARREADY;
    logic [31:0] WDATA, RDATA;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP, RRESP;
    logic        BVALID, BREADY;
    logic        RLAST, RVALID, RREADY;

    always #5 ACLK = ~ACLK;

    axi4_burst_master #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RLAST(RLAST), .RVALID(RVALID), .RRESP(RRESP), .RREADY(RREADY)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference memory (bench expectation) and slave memory (what the DUT wrote)
    logic [31:0] ref_mem [0:255];
    logic [31:0] slv_mem [0:255];

    // scoreboard queues
    logic [28:0] exp_aw_q [$];
    logic [28:0] exp_ar_q [$];
    logic [31:0] exp_w_q [$];
    logic        exp_wlast_q [$];
    logic [31:0] exp_r_q [$];
    logic        exp_rlast_q [$];
    logic [1:0]  exp_resp_q [$];
    int          exp_beats_q [$];

    // slave configuration
    logic       awready_cfg = 1'b1;
    logic [1:0] bresp_cfg   = 2'b00;
    int         rlast_at_cfg   = -1;
    int         rresp_beat_cfg = -1;

    int done_cnt     = 0;
    int beat_cnt     = 0;
    int axvalid_seen = 0;

    // slave state
    logic [7:0] w_base, r_base;
    int         w_idx, r_idx, r_last_idx;
    logic       b_pending;

    task automatic slave_drive_r();
        RDATA = slv_mem[(int'(r_base) + r_idx) & 255];
        RLAST = (r_idx == r_last_idx);
        RRESP = (r_idx == rresp_beat_cfg) ? 2'b01 : 2'b00;
    endtask

    // Slave model and output monitor: sample at negedge, respond after posedge
    initial begin : slave_monitor
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 2'b00;
        b_pending = 1'b0; w_base = '0; r_base = '0; w_idx = 0; r_idx = 0; r_last_idx = 0;
        forever begin
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            if (AWVALID || ARVALID) axvalid_seen++;
            if (aw_hs) begin
                if (exp_aw_q.size() == 0) check_value("aw_unexpected", 32'd1, 32'd0);
                else check_value("aw_fields", {3'b0, AWADDR, AWLEN, AWSIZE, AWBURST},
                                 {3'b0, exp_aw_q.pop_front()});
                w_base = AWADDR[9:2];
                w_idx  = 0;
            end
            if (ar_hs) begin
                if (exp_ar_q.size() == 0) check_value("ar_unexpected", 32'd1, 32'd0);
                else check_value("ar_fields", {3'b0, ARADDR, ARLEN, ARSIZE, ARBURST},
                                 {3'b0, exp_ar_q.pop_front()});
                r_base     = ARADDR[9:2];
                r_last_idx = (rlast_at_cfg >= 0) ? rlast_at_cfg : int'(ARLEN);
            end
            if (w_hs) begin
                if (exp_w_q.size() == 0) check_value("w_unexpected", 32'd1, 32'd0);
                else begin
                    check_value("wdata", WDATA, exp_w_q.pop_front());
                    check_value("wlast", 32'(WLAST), 32'(exp_wlast_q.pop_front()));
                end
                slv_mem[(int'(w_base) + w_idx) & 255] = WDATA;
                w_idx++;
                if (WLAST) b_pending = 1'b1;
            end
            if (RVALID) check_value("rready_follows", 32'(RREADY), 32'(rd_ready));
            if (rd_valid && rd_ready) begin
                beat_cnt++;
                if (exp_r_q.size() == 0) check_value("rd_unexpected", 32'd1, 32'd0);
                else begin
                    check_value("rd_data", rd_data, exp_r_q.pop_front());
                    check_value("rd_last", 32'(rd_last), 32'(exp_rlast_q.pop_front()));
                end
            end
            if (done) begin
                check_value("no_cmd_ready_with_done", 32'(cmd_ready), 32'd0);
                if (exp_resp_q.size() == 0) check_value("done_unexpected", 32'd1, 32'd0);
                else begin
                    check_value("done_resp", 32'(done_resp), 32'(exp_resp_q.pop_front()));
                    check_value("beat_count", 32'(beat_cnt), 32'(exp_beats_q.pop_front()));
                end
                $display("[TB] txn %0d done resp=%0b read_beats=%0d", done_cnt, done_resp, beat_cnt);
                beat_cnt = 0;
                done_cnt++;
            end
            @(posedge ACLK);
            #1;
            AWREADY = awready_cfg;
            ARREADY = 1'b1;
            WREADY  = 1'b1;
            if (b_hs) BVALID = 1'b0;
            if (b_pending) begin
                BVALID    = 1'b1;
                BRESP     = bresp_cfg;
                b_pending = 1'b0;
            end
            if (ar_hs) begin
                r_idx  = 0;
                RVALID = 1'b1;
                slave_drive_r();
            end else if (r_hs) begin
                if (RLAST) begin
                    RVALID = 1'b0;
                    RLAST  = 1'b0;
                    RRESP  = 2'b00;
                end else begin
                    r_idx++;
                    slave_drive_r();
                end
            end
            if (!ARESET) begin
                BVALID = 1'b0; RVALID = 1'b0; RLAST = 1'b0; b_pending = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic [1:0] b);
        bit ok = 1'b0;
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
        cmd_len = l; cmd_size = s; cmd_burst = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge ACLK);
            #1;
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge ACLK);
            #1;
        end
        if (!ok) check_value("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge ACLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input bit toggle);
        bit ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge ACLK);
            #1;
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            @(posedge ACLK);
            #1;
            rd_ready = toggle ? ~rd_ready : 1'b1;
        end
        if (!ok) check_value("done_timeout", 32'd0, 32'd1);
        rd_ready = 1'b1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] l,
                            input logic [31:0] base, input logic [1:0] bresp);
        int target = done_cnt + 1;
        bresp_cfg = bresp;
        exp_aw_q.push_back({a, l, 3'd2, 2'b01});
        exp_resp_q.push_back(bresp);
        exp_beats_q.push_back(0);
        send_cmd(1'b1, a, l, 3'd2, 2'b01);
        for (int i = 0; i <= int'(l); i++) begin
            bit ok;
            logic [31:0] d;
            ok = 1'b0;
            d  = base + 32'(i);
            exp_w_q.push_back(d);
            exp_wlast_q.push_back(i == int'(l));
            ref_mem[(int'(a[9:2]) + i) & 255] = d;
            wr_valid = 1'b1;
            wr_data  = d;
            for (int n = 0; n < 50; n++) begin
                @(negedge ACLK);
                #1;
                if (wr_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge ACLK);
                #1;
            end
            if (!ok) check_value("wr_ready_timeout", 32'd0, 32'd1);
            @(posedge ACLK);
            #1;
        end
        wr_valid = 1'b0;
        wait_done(target, 1'b0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [1:0] b,
                           input int rlast_at, input int rresp_beat, input bit toggle,
                           input logic [1:0] exp_resp);
        int target = done_cnt + 1;
        int nb;
        rlast_at_cfg   = rlast_at;
        rresp_beat_cfg = rresp_beat;
        nb = (rlast_at >= 0) ? rlast_at + 1 : int'(l) + 1;
        exp_ar_q.push_back({a, l, 3'd2, b});
        for (int i = 0; i < nb; i++) begin
            exp_r_q.push_back(ref_mem[(int'(a[9:2]) + i) & 255]);
            exp_rlast_q.push_back(i == nb - 1);
        end
        exp_beats_q.push_back(nb);
        exp_resp_q.push_back(exp_resp);
        send_cmd(1'b0, a, l, 3'd2, b);
        wait_done(target, toggle);
        rlast_at_cfg   = -1;
        rresp_beat_cfg = -1;
    endtask

    task automatic do_illegal(input logic wr, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b);
        int seen0 = axvalid_seen;
        exp_resp_q.push_back(2'b10);
        exp_beats_q.push_back(0);
        send_cmd(wr, 16'h0100, l, s, b);
        check_value("illegal_no_done_in_chk", 32'(done), 32'd0);
        @(posedge ACLK);
        #1;
        check_value("illegal_done_pulse", 32'(done), 32'd1);
        check_value("illegal_done_resp", 32'(done_resp), 32'd2);
        @(posedge ACLK);
        #1;
        check_value("illegal_done_one_cycle", 32'(done), 32'd0);
        check_value("illegal_no_axvalid", 32'(axvalid_seen - seen0), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int n0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'hC000_0000 | 32'(i);
            slv_mem[i] = 32'hC000_0000 | 32'(i);
        end
        ARESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        #1;
        // reset state
        check_value("rst_awvalid", 32'(AWVALID), 32'd0);
        check_value("rst_arvalid", 32'(ARVALID), 32'd0);
        check_value("rst_bready", 32'(BREADY), 32'd0);
        check_value("rst_rready", 32'(RREADY), 32'd0);
        check_value("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_value("rst_done", 32'(done), 32'd0);
        check_value("rst_done_resp", 32'(done_resp), 32'd0);
        check_value("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_value("rst_awaddr", 32'(AWADDR), 32'd0);
        check_value("rst_awlen", 32'(AWLEN), 32'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        #1;
        check_value("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // write then read back the same INCR burst
        do_write(16'h0010, 8'd3, 32'h0000_00A0, 2'b00);
        do_read(16'h0010, 8'd3, 2'b01, -1, -1, 1'b0, 2'b00);
        // 8-beat read with a toggling consumer
        do_read(16'h0040, 8'd7, 2'b01, -1, -1, 1'b1, 2'b00);
        // illegal commands: reserved burst, oversize beat, bad WRAP length
        do_illegal(1'b1, 8'd3, 3'd2, 2'b11);
        do_illegal(1'b0, 8'd0, 3'd3, 2'b01);
        do_illegal(1'b0, 8'd2, 3'd2, 2'b10);
        // early RLAST on beat 2, then a normal read is accepted
        do_read(16'h0010, 8'd3, 2'b01, 1, -1, 1'b0, 2'b10);
        do_read(16'h0010, 8'd0, 2'b01, -1, -1, 1'b0, 2'b00);
        // late RLAST: one extra beat
        do_read(16'h0010, 8'd3, 2'b01, 4, -1, 1'b0, 2'b10);
        // write with SLVERR response, read with EXOKAY on one beat
        do_write(16'h0020, 8'd1, 32'h0000_00B0, 2'b10);
        do_read(16'h0020, 8'd1, 2'b01, -1, 1, 1'b0, 2'b01);
        // legal WRAP burst on an aligned boundary
        do_read(16'h0010, 8'd3, 2'b10, -1, -1, 1'b0, 2'b00);

`ifdef AXI_MASTER_TIMEOUT_EN
        begin : timeout_test
            int cnt = 0;
            int target;
            awready_cfg = 1'b0;
            target = done_cnt + 1;
            exp_resp_q.push_back(2'b11);
            exp_beats_q.push_back(0);
            send_cmd(1'b1, 16'h0030, 8'd0, 3'd2, 2'b01);
            for (int n = 0; n < 60; n++) begin
                @(negedge ACLK);
                #1;
                if (AWVALID) cnt++;
                if (done_cnt >= target) break;
                @(posedge ACLK);
                #1;
            end
            check_value("timeout_awvalid_cycles", 32'(cnt), 32'd16);
            check_value("timeout_awvalid_dropped", 32'(AWVALID), 32'd0);
            check_value("timeout_done_seen", 32'(done_cnt), 32'(target));
            awready_cfg = 1'b1;
            @(posedge ACLK);
            #1;
        end
`endif

        // reset asserted mid-W clears outputs at once and produces no done
        begin : reset_mid_w
            bit ok = 1'b0;
            exp_aw_q.push_back({16'h0080, 8'd3, 3'd2, 2'b01});
            send_cmd(1'b1, 16'h0080, 8'd3, 3'd2, 2'b01);
            for (int n = 0; n < 50; n++) begin
                @(negedge ACLK);
                #1;
                if (wr_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge ACLK);
                #1;
            end
            check_value("midw_reached_w", 32'(ok), 32'd1);
            wr_valid = 1'b1;
            wr_data  = 32'h0000_0055;
            #1;
            check_value("midw_wvalid_pass", 32'(WVALID), 32'd1);
            n0 = done_cnt;
            ARESET = 1'b0;
            #1;
            check_value("midw_rst_wvalid", 32'(WVALID), 32'd0);
            check_value("midw_rst_wr_ready", 32'(wr_ready), 32'd0);
            check_value("midw_rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check_value("midw_rst_awaddr", 32'(AWADDR), 32'd0);
            check_value("midw_rst_done", 32'(done), 32'd0);
            wr_valid = 1'b0;
            repeat (2) @(posedge ACLK);
            #1;
            ARESET = 1'b1;
            repeat (5) @(posedge ACLK);
            @(negedge ACLK);
            #1;
            check_value("midw_no_done", 32'(done_cnt - n0), 32'd0);
            check_value("midw_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        // recovery after reset
        do_read(16'h0010, 8'd1, 2'b01, -1, -1, 1'b0, 2'b00);

        repeat (3) @(posedge ACLK);
        check_value("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);
        check_value("w_q_drained", 32'(exp_w_q.size()), 32'd0);
        check_value("r_q_drained", 32'(exp_r_q.size()), 32'd0);
        check_value("ar_q_drained", 32'(exp_ar_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Command-driven AXI4 master that drives the AXI4 memory slave directly downstream of it.
- Accepts one read or write burst command at a time and sequences the AW/W/B or AR/R channels.
- Streams write data in from a local valid/ready port and streams read data out to one.
- Reports completion with a one-cycle done pulse and the burst's accumulated response.

Parameters:
- DATA_WIDTH, 32, AXI data bus width in bits; a power of 2, at least 8.
- ADDR_WIDTH, 16, AXI address width in bits.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when AXI_MASTER_TIMEOUT_EN is defined.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  start address
- cmd_len  in  8  beats minus 1
- cmd_size  in  3  log2 of bytes per beat
- cmd_burst  in  2  FIXED / INCR / WRAP encoding
- wr_data  in  DATA_WIDTH  write data stream
- wr_valid  in  1  write data valid
- wr_ready  out  1  write data accepted
- rd_data  out  DATA_WIDTH  read data stream
- rd_last  out  1  final read beat
- rd_valid  out  1  read data valid
- rd_ready  in  1  consumer ready
- done  out  1  one-cycle completion pulse
- done_resp  out  2  accumulated response, valid while done = 1
- AWADDR/AWBURST/AWLEN/AWSIZE/AWVALID  out  ADDR_WIDTH/2/8/3/1  write address channel
- AWREADY  in  1  write address ready
- WDATA/WLAST/WVALID  out  DATA_WIDTH/1/1  write data channel
- WREADY  in  1  write data ready
- BRESP  in  2  write response
- BVALID  in  1  write response valid
- BREADY  out  1  write response ready
- ARADDR/ARBURST/ARLEN/ARSIZE/ARVALID  out  ADDR_WIDTH/2/8/3/1  read address channel
- ARREADY  in  1  read address ready
- RDATA  in  DATA_WIDTH  read data
- RLAST  in  1  last read beat
- RVALID  in  1  read data valid
- RRESP  in  2  read response
- RREADY  out  1  read data ready

Behaviour:
- Reset: ARESET low asynchronously forces state IDLE.
  - All VALID/READY outputs, done, rd_valid and rd_last go to 0.
  - done_resp = 0; the latched address/len/size/burst registers = 0.
  - Assertion mid-burst abandons the burst; no done pulse is produced.
- States: IDLE, CHK, AW, W, B, AR, R.
- IDLE:
  - cmd_ready = 1 (combinational from state).
  - On cmd_valid, latch all cmd_* fields; next state CHK.
- CHK (1 cycle): legality check on the latched command.
  - Illegal: burst == 2'b11; cmd_size > log2(DATA_WIDTH/8); or WRAP with len not in {1,3,7,15}.
  - Illegal command: done = 1 with done_resp = 2'b10, no AXI traffic, next state IDLE.
  - Legal command: beat counter = len, resp accumulator = 0; next state AW (write) or AR (read).
- AW / AR:
  - AxVALID is registered and set on entry; Ax* fields come from the latched command.
  - AxVALID and Ax* stay stable until AxREADY is sampled high.
  - Handshake moves to W / R and drops AxVALID the next cycle.
- W:
  - Combinational pass-through: WVALID = wr_valid, wr_ready = WREADY, WDATA = wr_data.
  - WLAST = (beat counter == 0).
  - Each WVALID & WREADY decrements the counter; the handshake carrying WLAST moves to B.
- B:
  - BREADY = 1.
  - On BVALID: done = 1 next cycle, done_resp = BRESP, next state IDLE.
- R:
  - Combinational pass-through: RREADY = rd_ready, rd_valid = RVALID, rd_data = RDATA, rd_last = RLAST.
  - Each handshake decrements the counter and ORs RRESP into the accumulator.
  - Handshake with RLAST: done = 1 next cycle; next state IDLE.
    - done_resp = accumulator | RRESP.
    - If the counter was not 0 (early RLAST), done_resp = 2'b10.
  - Counter already 0 and RLAST low on a handshake (late RLAST): set the sticky length-error flag, keep accepting beats until RLAST, then report 2'b10.
- Single outstanding transaction:
  - cmd_ready = 0 outside IDLE.
  - Read and write never overlap; an AW/AR valid never coexists with the other channel.
- done and cmd_ready are never high together in the same cycle.
  - A new command is accepted at the earliest in the cycle after done.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in AW, W, B, AR or R without a handshake on that state's channel; it clears on any handshake.
  - Reaching TIMEOUT_CYCLES drops all VALID/READY outputs, pulses done with done_resp = 2'b11, and returns to IDLE.
- Undefined: no watchdog; the FSM waits indefinitely.

Test Plan:
- Write INCR, addr 0x0010, len 3, size 2; wr stream 0xA0..0xA3 -> AW fields match; 4 W beats with WLAST on the 4th only; after BRESP = 0: done pulse, done_resp = 0.
- Read back the same burst with rd_ready always 1 -> rd_data 0xA0..0xA3, rd_last on beat 4, done_resp = 0.
- Read len 7 with rd_ready toggling every cycle -> RREADY follows rd_ready; no beat lost or duplicated; 8 beats delivered.
- Command burst = 2'b11 -> no AWVALID/ARVALID ever; done pulse 2 cycles after acceptance; done_resp = 2'b10.
- Slave asserts RLAST on beat 2 of a len 3 read -> done_resp = 2'b10; FSM returns to IDLE; next command accepted.
- With AXI_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, hold AWREADY low -> after 16 cycles AWVALID = 0, done_resp = 2'b11; ARESET pulse mid-W clears all outputs immediately.
